// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback buffer
// Provides the entry type held in the FIFO and the default data/address widths.
package wb_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest-wins lookup of a register address over the pending FIFO entries
// Ports: i_entries (entry storage), i_rptr/i_count (live window), i_addr (lookup address),
//        o_hit (a pending entry matches), o_data (its value, 0 on miss or address 0).
module wb_fwd_match
    import wb_pkg::wb_entry_t;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t                 i_entries [DEPTH],
    input  logic [PW-1:0]             i_rptr,
    input  logic [PW:0]               i_count,
    input  logic [wb_pkg::AW-1:0]     i_addr,
    output logic                      o_hit,
    output logic [wb_pkg::XLEN-1:0]   o_data
);
    logic [PW-1:0] w_idx;

    // Walk oldest to youngest so the last match, the youngest, is what remains.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rptr + PW'(k);
            if (k < int'(i_count) && i_addr != '0 && i_entries[w_idx].rd == i_addr) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end
endmodule

// File: rtl/wb_write_buffer.sv
// wb_write_buffer: in-order FIFO merging ALU and load results into the register-file write port
// Ports: alu_*/mem_* valid-ready result inputs (mem has priority), rf_* write port driven by
//        the head entry, fwd_addr*/fwd_hit*/fwd_data* decode forwarding, count/empty/full status.
module wb_write_buffer
    import wb_pkg::wb_entry_t;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int AW    = wb_pkg::AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [AW-1:0]              fwd_addr1,
    input  logic [AW-1:0]              fwd_addr2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [XLEN-1:0]            fwd_data1,
    output logic [XLEN-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t      r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;

    logic           w_pop;
    logic           w_mem_need;
    logic           w_mem_push;
    logic           w_alu_push;
    logic [CW-1:0]  w_free;
    logic [PW-1:0]  w_alu_ptr;
    wb_entry_t      w_head;

    // The head always retires this edge when present, so its slot counts as free.
    assign w_pop      = r_count != '0;
    assign w_free     = CW'(DEPTH) - r_count + CW'(w_pop);
    assign w_mem_need = mem_valid && mem_rd != '0;
    assign mem_ready  = w_free >= CW'(1);
    assign alu_ready  = w_free >= CW'(1) + CW'(w_mem_need);
    // rd==0 transfers complete the handshake but are never stored.
    assign w_mem_push = w_mem_need && mem_ready;
    assign w_alu_push = alu_valid && alu_ready && alu_rd != '0;
    assign w_alu_ptr  = r_wptr + PW'(w_mem_push);

    assign w_head   = r_mem[r_rptr];
    assign rf_we    = w_pop;
    assign rf_waddr = w_pop ? w_head.rd : '0;
    assign rf_wdata = w_pop ? w_head.data : '0;
    assign count    = r_count;
    assign empty    = r_count == '0;
    assign full     = r_count == CW'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(w_mem_push) + PW'(w_alu_push);
            r_rptr  <= r_rptr + PW'(w_pop);
            r_count <= r_count - CW'(w_pop) + CW'(w_mem_push) + CW'(w_alu_push);
        end
    end

    // Mem entry is older than the ALU entry when both land on the same edge.
    always_ff @(posedge clk) begin
        if (w_mem_push) r_mem[r_wptr] <= '{rd: mem_rd, data: mem_data};
        if (w_alu_push) r_mem[w_alu_ptr] <= '{rd: alu_rd, data: alu_data};
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .i_entries (r_mem),
        .i_rptr    (r_rptr),
        .i_count   (r_count),
        .i_addr    (fwd_addr1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .i_entries (r_mem),
        .i_rptr    (r_rptr),
        .i_count   (r_count),
        .i_addr    (fwd_addr2),
        .o_hit     (fwd_hit2),
        .o_data    (fwd_data2)
    );
endmodule

// File: tb/tb_wb_write_buffer.sv
// tb_wb_write_buffer: directed self-checking bench for wb_write_buffer
module tb_wb_write_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_rd, mem_rd, rf_waddr, fwd_addr1, fwd_addr2;
    logic [31:0] alu_data, mem_data, rf_wdata, fwd_data1, fwd_data2;
    logic        rf_we, fwd_hit1, fwd_hit2, empty, full;
    logic [2:0]  count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [4:0]  q_rd [$];
    logic [31:0] q_d [$];
    int          mc;
    logic        exp_ar;

    wb_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
    endtask

    initial begin
        idle();
        fwd_addr1 = '0; fwd_addr2 = '0;
        rst = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h42;
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_hit1", fwd_hit1, 0);
        chk("rst_fdata1", fwd_data1, 0);

        rst = 1'b0;
        #1 chk("t1_mem_ready", mem_ready, 1);
        step();
        idle();
        #1;
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 8);
        chk("t1_wdata", rf_wdata, 32'h42);
        step();
        chk("t1_empty", empty, 1);
        chk("t1_we_off", rf_we, 0);

        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        #1 chk("t2_alu_ready", alu_ready, 1);
        step();
        idle();
        #1;
        chk("t2_count2", count, 2);
        chk("t2_waddr_a", rf_waddr, 3);
        chk("t2_wdata_a", rf_wdata, 32'h11);
        step();
        chk("t2_count1", count, 1);
        chk("t2_waddr_b", rf_waddr, 4);
        chk("t2_wdata_b", rf_wdata, 32'h22);
        step();
        chk("t2_count0", count, 0);

        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
        #1 chk("t3_alu_ready", alu_ready, 1);
        step();
        idle();
        #1;
        chk("t3_count", count, 0);
        chk("t3_we", rf_we, 0);

        mc = 0;
        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'h100 + i;
            alu_valid = 1'b1; alu_rd = 5'(20 + i); alu_data = 32'h200 + i;
            #1;
            exp_ar = (4 - mc + ((mc != 0) ? 1 : 0)) >= 2;
            chk("t4_alu_ready", alu_ready, exp_ar);
            chk("t4_full", full, mc == 4);
            chk("t4_we", rf_we, mc != 0);
            if (mc != 0) begin
                chk("t4_waddr", rf_waddr, q_rd[0]);
                chk("t4_wdata", rf_wdata, q_d[0]);
                void'(q_rd.pop_front()); void'(q_d.pop_front()); mc--;
            end
            q_rd.push_back(mem_rd); q_d.push_back(mem_data); mc++;
            if (exp_ar) begin
                q_rd.push_back(alu_rd); q_d.push_back(alu_data); mc++;
            end
            step();
        end
        idle();
        for (int i = 0; i < 6 && mc > 0; i++) begin
            #1;
            chk("t4d_we", rf_we, 1);
            chk("t4d_waddr", rf_waddr, q_rd[0]);
            chk("t4d_wdata", rf_wdata, q_d[0]);
            void'(q_rd.pop_front()); void'(q_d.pop_front()); mc--;
            step();
        end
        chk("t4_drained", count, 0);
        chk("t4_model_left", mc, 0);

        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h5;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h7;
        step();
        idle();
        fwd_addr1 = 5'd9; fwd_addr2 = 5'd10;
        #1;
        chk("t5_hit1", fwd_hit1, 1);
        chk("t5_fdata1", fwd_data1, 32'h7);
        chk("t5_hit2", fwd_hit2, 0);
        chk("t5_fdata2", fwd_data2, 0);
        chk("t5_wdata_old", rf_wdata, 32'h5);
        fwd_addr2 = 5'd0;
        #1;
        chk("t5_hit_zero", fwd_hit2, 0);
        step();
        chk("t5_wdata_young", rf_wdata, 32'h7);
        chk("t5_fdata1_b", fwd_data1, 32'h7);
        step();
        chk("t5_miss_after", fwd_hit1, 0);
        chk("t5_fdata_after", fwd_data1, 0);

        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hA1;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
        step();
        mem_rd = 5'd5; alu_rd = 5'd6;
        step();
        idle();
        #1 chk("t6_count3", count, 3);
        #1 rst = 1'b1;
        #1;
        chk("t6_count", count, 0);
        chk("t6_we", rf_we, 0);
        chk("t6_empty", empty, 1);
        step();
        rst = 1'b0;
        step();
        chk("t6_after", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_write_buffer.md
# wb_write_buffer

Writeback buffer that drives the single write port of `registerFile` (`we`, `WriteN`, `In`) from two result producers: the ALU pipe and the load/memory unit. It queues completed results in a small in-order FIFO, retires one entry per cycle into the register file, and exposes a forwarding lookup so decode can see values not yet written. It sits between EX/MEM result buses and the register file in the pipeline.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `AW`, 5: register address width.

Ports:
- `clk`  in  1  clock; everything updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  AW  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `mem_valid`, `mem_ready`, `mem_rd`, `mem_data`: same as the `alu_*` ports, for the load unit.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  AW  register-file write address.
- `rf_wdata`  out  XLEN  register-file write data.
- `fwd_addr1`, `fwd_addr2`  in  AW  decode read addresses.
- `fwd_hit1`, `fwd_hit2`  out  1  a pending entry matches.
- `fwd_data1`, `fwd_data2`  out  XLEN  forwarded value.
- `count`  out  $clog2(DEPTH)+1  entries held.
- `empty`, `full`  out  1  status flags.

## Operation
- A transfer occurs when `*_valid && *_ready` at a clock edge.
- `rd == 0` results are accepted and discarded. They never occupy a slot.
- The head entry drives the write port combinationally. `rf_we = !empty`, and `rf_waddr`/`rf_wdata` come from the head. The head pops at every edge where `!empty`, so the drain rate is one per cycle with no backpressure from the register file.
- Effective free slots: `free = DEPTH - count + (count != 0)`.
- `mem_ready = (free >= 1)`.
- `alu_ready = (free >= 1 + (mem_valid && mem_rd != 0))`. The memory result has priority.
- If both sources are accepted in the same cycle, the mem entry is enqueued first, then the ALU entry (two writes per edge).
- `count_next = count - pop + pushes`, with pushes in 0..2.
- Forwarding is combinational over valid entries only, not the current-cycle inputs. The youngest matching entry wins.
  - `fwd_addr == 0` gives hit=0 and data=0.
  - On a miss, `fwd_data` is 0.
- There is no state machine beyond pointers and count. Read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset values: `count=0`, `empty=1`, `full=0`, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `fwd_hit*=0`, `fwd_data*=0`. Pointers are 0. Entry storage need not be cleared.
- Latency: a result accepted at edge N (buffer empty) gives `rf_we=1` during cycle N+1 and is written to the register file at edge N+1.
- A full buffer with a pending pop still accepts one new result at the same edge (`free=1`).
- Simultaneous mem+ALU into an empty buffer: mem is written at edge N+1 and ALU at edge N+2.
- Two pending writes to the same `rd`: both are retired in order, and forwarding returns the younger.
- `rst` asserted mid-operation drops all pending entries immediately. Lost writes are acceptable; the pipeline is flushed with it.

## Structure
- Shared package `wb_pkg`: typedef `wb_entry_t` {`logic [AW-1:0] rd`, `logic [XLEN-1:0] data`} and the constants `XLEN=32` and `AW=5`.
- One sub-module, `wb_fwd_match`: a youngest-first priority match over the entry array. It is instantiated twice, once per read port.

## Test plan
1. Reset while `mem_valid=1` → all outputs are at their reset values; after release, `mem_rd=8`, `mem_data=0x42` → `rf_we=1`, `rf_waddr=8`, `rf_wdata=0x42` one cycle later, then `empty=1`.
2. Same cycle: `mem_rd=3`/`0x11` and `alu_rd=4`/`0x22` → `rf` writes x3=0x11, then x4=0x22 on consecutive cycles; `count` goes 2, 1, 0.
3. `alu_rd=0`, `alu_data=0xDEAD`, `alu_valid=1` → `alu_ready=1`, `count` stays 0, `rf_we` stays 0.
4. Fill to `full` by holding both sources valid → `alu_ready=0` whenever `free=1` and mem is valid; no entry is lost or duplicated (the scoreboard compares the write sequence with the accept sequence).
5. Enqueue x9=0x5, then x9=0x7, and set `fwd_addr1=9`, `fwd_addr2=10` → `fwd_hit1=1`, `fwd_data1=0x7`, `fwd_hit2=0`, `fwd_data2=0`.
6. Assert `rst` with 3 entries pending → `count=0` and `rf_we=0` immediately, before the next clock edge.
